// File: rtl/e1_buf_ram_arb_pkg.sv
// Shared definitions for the E1 sample buffer: direction codes, field widths,
// host FSM states and the buffer word-address helpers.
package e1_buf_ram_arb_pkg;

    localparam logic DIR_RX  = 1'b0;
    localparam logic DIR_TX  = 1'b1;
    localparam int   FRAME_W = 4;
    localparam int   TS_W    = 5;

    typedef enum logic [1:0] {
        H_IDLE,
        H_ACCESS,
        H_ACK
    } host_state_t;

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [TS_W-1:0]    ts;
    } e1_loc_t;

    // Word offset inside one multiframe slot; ts[1:0] picks the byte lane.
    function automatic logic [FRAME_W+2:0] slot_word(input e1_loc_t loc);
        return {loc.frame, loc.ts[4:2]};
    endfunction

    function automatic logic [3:0] lane_we(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/e1_buf_ram_arb_ram.sv
// Single-port 32-bit buffer RAM with per-byte write enables and a registered
// read port (read-before-write); shaped to map onto SPRAM/EBR.
module e1_buf_ram_arb_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // NOTE: memory array and read register have no reset so the RAM maps to a block primitive.
    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/e1_buf_ram_arb.sv
// E1 sample buffer: RX/TX pending capture, fixed-priority RAM arbiter
// (RX > TX > host), Wishbone host FSM and TX byte-lane output register.
module e1_buf_ram_arb
    import e1_buf_ram_arb_pkg::*;
#(
    parameter int MFW = 7,
    parameter int SW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        buf_rx_data,
    input  logic [4:0]        buf_rx_ts,
    input  logic [3:0]        buf_rx_frame,
    input  logic [MFW-1:0]    buf_rx_mf,
    input  logic              buf_rx_we,
    output logic              buf_rx_rdy,
    output logic [7:0]        buf_tx_data,
    input  logic [4:0]        buf_tx_ts,
    input  logic [3:0]        buf_tx_frame,
    input  logic [MFW-1:0]    buf_tx_mf,
    input  logic              buf_tx_re,
    output logic              buf_tx_rdy,
    input  logic [SW+7:0]     wb_addr,
    output logic [31:0]       wb_rdata,
    input  logic [31:0]       wb_wdata,
    input  logic [3:0]        wb_sel,
    input  logic              wb_we,
    input  logic              wb_cyc,
    output logic              wb_ack
);

    localparam int AW = SW + 8;

    logic            r_rx_pend_v, r_tx_pend_v, r_rx_rdy, r_tx_rdy;
    logic [SW-1:0]   r_rx_slot, r_tx_slot;
    e1_loc_t         r_rx_loc, r_tx_loc;
    logic [7:0]      r_rx_data;
    host_state_t     r_hst, w_hst_nxt;
    logic [AW-1:0]   r_h_addr;
    logic [31:0]     r_h_wdata;
    logic [3:0]      r_h_sel;
    logic            r_h_we;
    logic            r_tx_rd_v;
    logic [1:0]      r_tx_lane;
    logic [7:0]      r_tx_data;

    logic            w_rx_cap, w_tx_cap, w_rx_grant, w_tx_grant, w_h_grant, w_h_start;
    logic            w_rx_pend_nxt, w_tx_pend_nxt;
    logic            w_ram_en;
    logic [3:0]      w_ram_we;
    logic [AW-1:0]   w_ram_addr;
    logic [31:0]     w_ram_wdata, w_ram_rdata;
    logic [7:0]      w_tx_byte;
    logic            w_unused_mf;

    // Multiframe bits above the slot field only wrap the slot index.
    assign w_unused_mf = ^{buf_rx_mf[MFW-1:SW], buf_tx_mf[MFW-1:SW]};

    assign w_rx_cap      = buf_rx_we & r_rx_rdy;
    assign w_tx_cap      = buf_tx_re & r_tx_rdy;
    assign w_rx_grant    = r_rx_pend_v;
    assign w_tx_grant    = r_tx_pend_v & ~r_rx_pend_v;
    assign w_h_grant     = (r_hst == H_ACCESS);
    assign w_rx_pend_nxt = w_rx_cap | (r_rx_pend_v & ~w_rx_grant);
    assign w_tx_pend_nxt = w_tx_cap | (r_tx_pend_v & ~w_tx_grant);
    assign w_h_start     = (r_hst == H_IDLE) && (w_hst_nxt == H_ACCESS);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 4'b0000;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (w_rx_grant) begin
            w_ram_en    = 1'b1;
            w_ram_we    = lane_we(r_rx_loc.ts[1:0]);
            w_ram_addr  = {DIR_RX, r_rx_slot, slot_word(r_rx_loc)};
            w_ram_wdata = {4{r_rx_data}};
        end else if (w_tx_grant) begin
            w_ram_en    = 1'b1;
            w_ram_addr  = {DIR_TX, r_tx_slot, slot_word(r_tx_loc)};
        end else if (w_h_grant) begin
            w_ram_en    = 1'b1;
            w_ram_we    = r_h_we ? r_h_sel : 4'b0000;
            w_ram_addr  = r_h_addr;
            w_ram_wdata = r_h_wdata;
        end
    end

    // The host only leaves IDLE when no E1 access will be pending next cycle,
    // so ACCESS always owns the RAM.
    always_comb begin
        w_hst_nxt = r_hst;
        unique case (r_hst)
            H_IDLE:   if (wb_cyc && !wb_ack && !w_rx_pend_nxt && !w_tx_pend_nxt) w_hst_nxt = H_ACCESS;
            H_ACCESS: w_hst_nxt = H_ACK;
            H_ACK:    w_hst_nxt = H_IDLE;
            default:  w_hst_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_pend_v <= 1'b0;
            r_tx_pend_v <= 1'b0;
            r_rx_rdy    <= 1'b0;
            r_tx_rdy    <= 1'b0;
            r_hst       <= H_IDLE;
            r_tx_rd_v   <= 1'b0;
            r_tx_data   <= 8'h00;
        end else begin
            r_rx_pend_v <= w_rx_pend_nxt;
            r_tx_pend_v <= w_tx_pend_nxt;
            r_rx_rdy    <= ~w_rx_pend_nxt;
            r_tx_rdy    <= ~w_tx_pend_nxt;
            r_hst       <= w_hst_nxt;
            r_tx_rd_v   <= w_tx_grant;
            if (r_tx_rd_v) r_tx_data <= w_tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_cap) begin
            r_rx_slot <= buf_rx_mf[SW-1:0];
            r_rx_loc  <= {buf_rx_frame, buf_rx_ts};
            r_rx_data <= buf_rx_data;
        end
        if (w_tx_cap) begin
            r_tx_slot <= buf_tx_mf[SW-1:0];
            r_tx_loc  <= {buf_tx_frame, buf_tx_ts};
        end
        if (w_tx_grant) r_tx_lane <= r_tx_loc.ts[1:0];
        if (w_h_start) begin
            r_h_addr  <= wb_addr;
            r_h_wdata <= wb_wdata;
            r_h_sel   <= wb_sel;
            r_h_we    <= wb_we;
        end
    end

    e1_buf_ram_arb_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The TX byte is shown straight from the RAM in the cycle after the read
    // and held in r_tx_data afterwards.
    assign w_tx_byte   = w_ram_rdata[8*r_tx_lane +: 8];
    assign buf_tx_data = r_tx_rd_v ? w_tx_byte : r_tx_data;
    assign buf_rx_rdy  = r_rx_rdy;
    assign buf_tx_rdy  = r_tx_rdy;
    assign wb_ack      = (r_hst == H_ACK);
    assign wb_rdata    = wb_ack ? w_ram_rdata : 32'h0;

endmodule

// File: tb/tb_e1_buf_ram_arb.sv
// Scoreboard bench for e1_buf_ram_arb: byte-array reference model of the
// buffer, randomized E1/host traffic and directed corner cases.
module tb_e1_buf_ram_arb;

    localparam int MFW    = 7;
    localparam int SW     = 3;
    localparam int AW     = SW + 8;
    localparam int NWORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]     buf_rx_data = '0;
    logic [4:0]     buf_rx_ts = '0;
    logic [3:0]     buf_rx_frame = '0;
    logic [MFW-1:0] buf_rx_mf = '0;
    logic           buf_rx_we = 1'b0;
    logic           buf_rx_rdy;
    logic [7:0]     buf_tx_data;
    logic [4:0]     buf_tx_ts = '0;
    logic [3:0]     buf_tx_frame = '0;
    logic [MFW-1:0] buf_tx_mf = '0;
    logic           buf_tx_re = 1'b0;
    logic           buf_tx_rdy;
    logic [AW-1:0]  wb_addr = '0;
    logic [31:0]    wb_rdata;
    logic [31:0]    wb_wdata = '0;
    logic [3:0]     wb_sel = '0;
    logic           wb_we = 1'b0;
    logic           wb_cyc = 1'b0;
    logic           wb_ack;

    e1_buf_ram_arb #(.MFW(MFW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .buf_rx_data(buf_rx_data), .buf_rx_ts(buf_rx_ts), .buf_rx_frame(buf_rx_frame),
        .buf_rx_mf(buf_rx_mf), .buf_rx_we(buf_rx_we), .buf_rx_rdy(buf_rx_rdy),
        .buf_tx_data(buf_tx_data), .buf_tx_ts(buf_tx_ts), .buf_tx_frame(buf_tx_frame),
        .buf_tx_mf(buf_tx_mf), .buf_tx_re(buf_tx_re), .buf_tx_rdy(buf_tx_rdy),
        .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata), .wb_sel(wb_sel),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer as plain bytes, word index from the address rule.
    logic [7:0] m_mem [NWORDS][4];

    function automatic int word_of(input int dir, input int mf, input int fr, input int ts);
        return dir * (NWORDS / 2) + (mf % (1 << SW)) * 128 + fr * 8 + ts / 4;
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {m_mem[w][3], m_mem[w][2], m_mem[w][1], m_mem[w][0]};
    endfunction

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } hexp_t;

    logic [7:0] tx_exp_q [$];
    hexp_t      h_exp_q [$];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drivers: called and returning at #1 after a rising edge.
    task automatic rx_write(input int mf, input int fr, input int ts, input logic [7:0] d);
        int n = 0;
        while (!buf_rx_rdy && n < 10) begin @(posedge clk); #1; n++; end
        check("rx_rdy_before_strobe", 32'(buf_rx_rdy), 1);
        buf_rx_we = 1'b1; buf_rx_mf = MFW'(mf); buf_rx_frame = 4'(fr);
        buf_rx_ts = 5'(ts); buf_rx_data = d;
        m_mem[word_of(0, mf, fr, ts)][ts % 4] = d;
        @(posedge clk); #1;
        buf_rx_we = 1'b0;
    endtask

    task automatic tx_read(input int mf, input int fr, input int ts);
        int n = 0;
        while (!buf_tx_rdy && n < 10) begin @(posedge clk); #1; n++; end
        check("tx_rdy_before_strobe", 32'(buf_tx_rdy), 1);
        buf_tx_re = 1'b1; buf_tx_mf = MFW'(mf); buf_tx_frame = 4'(fr); buf_tx_ts = 5'(ts);
        tx_exp_q.push_back(m_mem[word_of(1, mf, fr, ts)][ts % 4]);
        @(posedge clk); #1;
        buf_tx_re = 1'b0;
    endtask

    task automatic host_xfer(input bit we, input int w, input logic [31:0] wd,
                             input logic [3:0] sel, input bit keep);
        int n = 0;
        wb_cyc = 1'b1; wb_we = we; wb_addr = AW'(w); wb_wdata = wd; wb_sel = sel;
        if (we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) m_mem[w][b] = wd[8*b +: 8];
            h_exp_q.push_back('{is_rd: 1'b0, data: 32'h0});
        end else begin
            h_exp_q.push_back('{is_rd: 1'b1, data: model_word(w)});
        end
        do begin @(negedge clk); n++; end while (!wb_ack && n < 40);
        check("host_ack_seen", 32'(wb_ack), 1);
        @(posedge clk); #1;
        if (!keep) wb_cyc = 1'b0;
    endtask

    // Monitors: E1 turnaround and TX data, host ack and read data.
    bit rx_wait = 0, tx_wait = 0, prev_ack = 0;
    int rx_cnt = 0, tx_cnt = 0, rx_turn = 0, tx_turn = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_wait = 0;
            tx_wait = 0;
        end else begin
            if (rx_wait) begin
                rx_cnt++;
                if (buf_rx_rdy || rx_cnt > 3) begin
                    check("rx_rdy_low_max3", 32'(rx_cnt <= 3), 1);
                    rx_turn = rx_cnt;
                    rx_wait = 0;
                end
            end
            if (buf_rx_we && buf_rx_rdy && !rx_wait) begin rx_wait = 1; rx_cnt = 0; end
            if (tx_wait) begin
                tx_cnt++;
                if (buf_tx_rdy || tx_cnt > 3) begin
                    check("tx_rdy_low_max3", 32'(tx_cnt <= 3), 1);
                    tx_turn = tx_cnt;
                    tx_wait = 0;
                    check("tx_exp_available", 32'(tx_exp_q.size() != 0), 1);
                    if (tx_exp_q.size() != 0) begin
                        logic [7:0] e;
                        e = tx_exp_q.pop_front();
                        check("buf_tx_data", 32'(buf_tx_data), 32'(e));
                    end
                end
            end
            if (buf_tx_re && buf_tx_rdy && !tx_wait) begin tx_wait = 1; tx_cnt = 0; end
        end
    end

    always @(negedge clk) begin
        if (wb_ack) begin
            check("wb_ack_not_back_to_back", 32'(prev_ack), 0);
            check("host_exp_available", 32'(h_exp_q.size() != 0), 1);
            if (h_exp_q.size() != 0) begin
                hexp_t e;
                e = h_exp_q.pop_front();
                if (e.is_rd) check("wb_rdata", wb_rdata, e.data);
            end
        end else begin
            check("wb_rdata_zero_without_ack", wb_rdata, 0);
        end
        prev_ack = wb_ack;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_rdy", 32'(buf_rx_rdy), 0);
        check("reset_tx_rdy", 32'(buf_tx_rdy), 0);
        check("reset_tx_data", 32'(buf_tx_data), 0);
        check("reset_wb_ack", 32'(wb_ack), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        idle(1);
        check("rx_rdy_after_reset", 32'(buf_rx_rdy), 1);
        check("tx_rdy_after_reset", 32'(buf_tx_rdy), 1);

        // Fill the whole buffer so the model is fully known, then some partial writes.
        for (int w = 0; w < NWORDS; w++) host_xfer(1'b1, w, $urandom, 4'hF, 1'b1);
        for (int i = 0; i < 64; i++)
            host_xfer(1'b1, $urandom_range(0, NWORDS - 1), $urandom, 4'($urandom_range(0, 15)), 1'b1);
        for (int i = 0; i < 16; i++) host_xfer(1'b0, $urandom_range(0, NWORDS - 1), 0, 0, 1'b1);
        wb_cyc = 1'b0;
        idle(2);

        // RX byte lands in lane 2 of {0,5,3,1}; rdy low for exactly one cycle.
        rx_write(5, 3, 6, 8'hA5);
        idle(3);
        check("rx_single_turnaround", 32'(rx_turn), 2);
        host_xfer(1'b0, 5 * 128 + 3 * 8 + 1, 0, 0, 1'b0);
        idle(2);

        // Host-written TX word served to E1 lane 3, then held.
        host_xfer(1'b1, 1024 + 2 * 128, 32'h44332211, 4'hF, 1'b0);
        tx_read(2, 0, 3);
        idle(6);
        check("tx_data_held", 32'(buf_tx_data), 32'h44);

        // Simultaneous RX write, TX read and host read of the same RX word.
        buf_rx_we = 1'b1; buf_rx_mf = 7'd1; buf_rx_frame = 4'd9; buf_rx_ts = 5'd13; buf_rx_data = 8'h3C;
        m_mem[word_of(0, 1, 9, 13)][1] = 8'h3C;
        buf_tx_re = 1'b1; buf_tx_mf = 7'd6; buf_tx_frame = 4'd2; buf_tx_ts = 5'd30;
        tx_exp_q.push_back(m_mem[word_of(1, 6, 2, 30)][2]);
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = AW'(word_of(0, 1, 9, 13));
        h_exp_q.push_back('{is_rd: 1'b1, data: model_word(word_of(0, 1, 9, 13))});
        @(posedge clk); #1;
        buf_rx_we = 1'b0; buf_tx_re = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("contend_ack_cycle%0d", k), 32'(wb_ack), 32'(k == 4));
        end
        @(posedge clk); #1; wb_cyc = 1'b0;
        idle(3);
        check("contend_rx_turnaround", 32'(rx_turn), 2);
        check("contend_tx_turnaround", 32'(tx_turn), 3);

        // Multiframe 0x0D wraps to slot 5.
        rx_write(8'h0D, 7, 17, 8'h5C);
        idle(2);
        host_xfer(1'b0, 5 * 128 + 7 * 8 + 4, 0, 0, 1'b0);
        idle(2);

        // Reset asserted while the host is in ACCESS: no ack, rdy low then back.
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = '0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; wb_cyc = 1'b0;
        @(negedge clk);
        check("rst_access_no_ack", 32'(wb_ack), 0);
        check("rst_rx_rdy_low", 32'(buf_rx_rdy), 0);
        check("rst_tx_rdy_low", 32'(buf_tx_rdy), 0);
        check("rst_tx_data_zero", 32'(buf_tx_data), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_no_ack", 32'(wb_ack), 0);
        check("rst_release_rx_rdy_still_low", 32'(buf_rx_rdy), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_release_rx_rdy_high", 32'(buf_rx_rdy), 1);
        check("rst_release_tx_rdy_high", 32'(buf_tx_rdy), 1);
        @(posedge clk); #1;

        // Stress 1: E1 RX writes and TX reads at random pace, host back-to-back TX reads.
        fork
            repeat (2000) begin
                rx_write($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 31), 8'($urandom));
                idle($urandom_range(0, 3));
            end
            repeat (2000) begin
                tx_read($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 31));
                idle($urandom_range(0, 3));
            end
            begin
                repeat (600) host_xfer(1'b0, 1024 + $urandom_range(0, 1023), 0, 0, 1'b1);
                wb_cyc = 1'b0;
            end
        join
        idle(4);

        // Stress 2: host drains every RX word while E1 keeps reading TX.
        fork
            begin
                for (int w = 0; w < NWORDS / 2; w++) host_xfer(1'b0, w, 0, 0, 1'b1);
                wb_cyc = 1'b0;
            end
            repeat (1000) begin
                tx_read($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 31));
                idle($urandom_range(0, 2));
            end
        join
        idle(8);

        check("tx_queue_drained", 32'(tx_exp_q.size()), 0);
        check("host_queue_drained", 32'(h_exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
